alu_bist_ctrl: RTL

- Sequences pseudorandom logic BIST of the execute-stage primary ALU.
- Requests a pipeline stall, drives LFSR patterns into the ALU, and compacts ALU results into a 32-bit MISR.
- Compares the final signature against a golden value and reports pass/fail plus a sticky hardware fault flag.
- Sits beside the execute stage; the top level muxes its pattern outputs onto ALU inputs while test_en=1.

---
 rtl/alu_bist_pkg.sv | 34 +++
 rtl/bist_misr32.sv | 26 ++
 rtl/alu_bist_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and helpers for the execute-stage ALU logic BIST.
// Holds the FSM encoding, default constants and the Galois step functions.
package alu_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        RUN     = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [31:0] POLY_DEF   = 32'h8020_0003;
    localparam logic [31:0] GOLDEN_DEF = 32'h81c6_f051;
    localparam logic [31:0] SEED_DEF   = 32'hACE1_0001;

    // Right-shifting Galois step used to generate patterns.
    function automatic logic [31:0] lfsr_step(
        input logic [31:0] value,
        input logic [31:0] poly
    );
        return (value >> 1) ^ (value[0] ? poly : 32'h0);
    endfunction

    // Left-shifting Galois step used to compact results.
    function automatic logic [31:0] misr_step(
        input logic [31:0] value,
        input logic [31:0] poly
    );
        return {value[30:0], 1'b0} ^ (value[31] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/bist_misr32.sv
// 32-bit multiple-input signature register for ALU result compaction.
// Clear has priority over the compaction enable.
module bist_misr32
    import alu_bist_pkg::*;
#(
    parameter logic [31:0] POLY = POLY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] sig
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig <= 32'h0;
        end else if (clr) begin
            sig <= 32'h0;
        end else if (en) begin
            sig <= misr_step(sig, POLY) ^ data;
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Pseudorandom logic BIST sequencer for the primary execute-stage ALU.
// Define ALU_BIST_TIMEOUT_EN to add the DRAIN timeout and bist_timeout output.
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int          N_PATTERNS  = 255,
    parameter int          ALU_LATENCY = 1,
    parameter logic [31:0] LFSR_SEED   = SEED_DEF,
    parameter logic [31:0] GOLDEN_SIG  = GOLDEN_DEF,
    parameter logic [31:0] POLY        = POLY_DEF
`ifdef ALU_BIST_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 1024
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bist_start,
    input  logic        stall_ack,
    input  logic [31:0] alu_result,
    output logic        stall_req,
    output logic        test_en,
    output logic [31:0] pattern_a,
    output logic [31:0] pattern_b,
    output logic [2:0]  pattern_op,
    output logic        bist_done,
    output logic        bist_pass,
    output logic        fault_flag
`ifdef ALU_BIST_TIMEOUT_EN
    ,
    output logic        bist_timeout
`endif
);

    localparam logic [15:0] LAST_PAT = 16'(N_PATTERNS - 1);
    localparam logic [15:0] N_SMP    = 16'(N_PATTERNS);

    state_t                 state, state_n;
    logic [31:0]            lfsr;
    logic [15:0]            pat_cnt;
    logic [15:0]            smp_cnt;
    logic [ALU_LATENCY-1:0] valid_pipe;
    logic [31:0]            sig;
    logic                   smp_en;
    logic                   start_run;
    logic                   last_pat;
    logic                   all_smp;
    logic                   timeout_hit;

    assign smp_en    = valid_pipe[ALU_LATENCY-1];
    assign start_run = (state == DRAIN) && stall_ack;
    assign last_pat  = (pat_cnt == LAST_PAT);
    assign all_smp   = (smp_cnt == N_SMP);

`ifdef ALU_BIST_TIMEOUT_EN
    logic [31:0] to_cnt;

    assign timeout_hit = (state == DRAIN) && !stall_ack &&
                         (to_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= 32'h0;
        end else if (state != DRAIN) begin
            to_cnt <= 32'h0;
        end else begin
            to_cnt <= to_cnt + 32'h1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bist_start) state_n = DRAIN;
            DRAIN: begin
                if (stall_ack)        state_n = RUN;
                else if (timeout_hit) state_n = DONE;
            end
            RUN:     if (last_pat) state_n = FLUSH;
            FLUSH:   if (all_smp) state_n = COMPARE;
            COMPARE: state_n = DONE;
            DONE:    if (!bist_start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // lfsr runs one step ahead of the pattern registers it feeds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr       <= LFSR_SEED;
            pat_cnt    <= 16'h0;
            smp_cnt    <= 16'h0;
            valid_pipe <= '0;
            pattern_a  <= 32'h0;
            pattern_b  <= 32'h0;
            pattern_op <= 3'h0;
        end else begin
            valid_pipe <= ALU_LATENCY'({valid_pipe, test_en});
            if (smp_en) smp_cnt <= smp_cnt + 16'h1;
            if (start_run) begin
                lfsr       <= lfsr_step(LFSR_SEED, POLY);
                pattern_a  <= LFSR_SEED;
                pattern_b  <= {LFSR_SEED[15:0], LFSR_SEED[31:16]};
                pattern_op <= LFSR_SEED[2:0];
                pat_cnt    <= 16'h0;
                smp_cnt    <= 16'h0;
            end else if (state == RUN && !last_pat) begin
                lfsr       <= lfsr_step(lfsr, POLY);
                pattern_a  <= lfsr;
                pattern_b  <= {lfsr[15:0], lfsr[31:16]};
                pattern_op <= lfsr[2:0];
                pat_cnt    <= pat_cnt + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_req  <= 1'b0;
            test_en    <= 1'b0;
            bist_done  <= 1'b0;
            bist_pass  <= 1'b0;
            fault_flag <= 1'b0;
        end else begin
            stall_req <= state_n inside {DRAIN, RUN, FLUSH, COMPARE};
            test_en   <= (state_n == RUN);
            bist_done <= (state_n == DONE);
            if (state == IDLE && bist_start) begin
                bist_pass  <= 1'b0;
                fault_flag <= 1'b0;
            end
            if (state == COMPARE) begin
                bist_pass  <= (sig == GOLDEN_SIG);
                fault_flag <= (sig != GOLDEN_SIG);
            end
        end
    end

`ifdef ALU_BIST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bist_timeout <= 1'b0;
        end else if (state == IDLE && bist_start) begin
            bist_timeout <= 1'b0;
        end else if (timeout_hit) begin
            bist_timeout <= 1'b1;
        end
    end
`endif

    bist_misr32 #(
        .POLY (POLY)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_run),
        .en   (smp_en),
        .data (alu_result),
        .sig  (sig)
    );

endmodule
